// File: rtl/divu_8by4_seq.sv
// divu_8by4_seq: sequential unsigned restoring divider, one quotient bit per clock
//
// Ports:
//   clk        in   1      system clock, all state on rising edge
//   rst        in   1      synchronous reset, active-high
//   start      in   1      request, sampled only in IDLE
//   dividend   in   DVD_W  unsigned dividend, latched on accepted start
//   divisor    in   DVS_W  unsigned divisor, latched on accepted start
//   busy       out  1      high in CALC and DONE
//   done       out  1      one-cycle pulse, result valid
//   quotient   out  DVD_W  quotient, held until next result
//   remainder  out  DVS_W  remainder, held until next result
//   div_zero   out  1      divide-by-zero flag
//
// Macro DIVU_ZERO_TRAP_EN: when defined, a zero divisor skips the iteration and
// reports quotient=all-ones, remainder=dividend LSBs, div_zero=1 after one edge.
// When undefined the normal iteration runs and div_zero is tied low.
module divu_8by4_seq #(
   parameter int DVD_W = 8,
   parameter int DVS_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DVS_W-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [DVD_W-1:0] quotient,
   output logic [DVS_W-1:0] remainder,
   output logic             div_zero
);
   localparam int CNT_W = $clog2(DVD_W);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t           state_q;
   logic [DVD_W-1:0] dvd_q, q_q, q_d, quot_q;
   logic [DVS_W-1:0] dvs_q, rem_q;
   logic [DVS_W:0]   r_q, r_sh, r_d;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q, done_q, ge;
`ifdef DIVU_ZERO_TRAP_EN
   logic             zf_q, dz_q;
   assign div_zero = dz_q;
`else
   assign div_zero = 1'b0;
`endif
   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quot_q;
   assign remainder = rem_q;
   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      r_sh = {r_q[DVS_W-1:0], dvd_q[DVD_W-1]};
      ge   = r_sh >= {1'b0, dvs_q};
      r_d  = ge ? r_sh - {1'b0, dvs_q} : r_sh;
      q_d  = {q_q[DVD_W-2:0], ge};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
`ifdef DIVU_ZERO_TRAP_EN
         zf_q    <= 1'b0;
         dz_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  dvd_q   <= dividend;
                  dvs_q   <= divisor;
                  r_q     <= '0;
                  q_q     <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= CALC;
`ifdef DIVU_ZERO_TRAP_EN
                  zf_q    <= divisor == '0;
`endif
               end
            end
            CALC: begin
`ifdef DIVU_ZERO_TRAP_EN
               // Zero divisor spends a single CALC cycle and reports the trap result.
               if (zf_q) begin
                  quot_q  <= '1;
                  rem_q   <= dvd_q[DVS_W-1:0];
                  dz_q    <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else
`endif
               begin
                  r_q   <= r_d;
                  q_q   <= q_d;
                  dvd_q <= {dvd_q[DVD_W-2:0], 1'b0};
                  cnt_q <= cnt_q + 1'b1;
                  // Last iteration publishes the result straight from the step logic.
                  if (cnt_q == CNT_W'(DVD_W - 1)) begin
                     quot_q  <= q_d;
                     rem_q   <= r_d[DVS_W-1:0];
                     done_q  <= 1'b1;
                     state_q <= DONE;
`ifdef DIVU_ZERO_TRAP_EN
                     dz_q    <= 1'b0;
`endif
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
